// File: rtl/attn_pkg.sv
// Shared types, widths and arithmetic helpers for the attention pipeline stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package attn_pkg;

  localparam int DATA_W  = 16;
  localparam int TOK_DIM = 4;
  localparam int TOK_NUM = 8;
  localparam int FRAC_W  = 8;

  // Full-precision products plus enough headroom for TOK_NUM terms.
  localparam int ACC_W = 2 * DATA_W + $clog2(TOK_NUM);
  localparam int IDX_W = (TOK_NUM > 1) ? $clog2(TOK_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One extra bit so the rounding bias can never wrap the accumulator.
  localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W + 1)'(-(2 ** (DATA_W - 1)));

  // Round half up at FRAC_W, then clamp to the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    biased  = {acc[ACC_W-1], acc} + RND_BIAS;
    shifted = biased >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/weighted_row_mac.sv
// TOKEN_DIM parallel signed MACs: acc[j] += s * v[j]; row output is round/sat of the updated sum.
// Latency: accumulators update on the clock edge; row_sat is combinational from acc and inputs.
// Backpressure: none; the caller gates accumulation with en and restarts with clr.
module weighted_row_mac
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int TOKEN_DIM  = TOK_DIM
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              en,
  input  logic signed [DATA_WIDTH-1:0]      s_val,
  input  logic [TOKEN_DIM*DATA_WIDTH-1:0]   v_row,
  output logic [TOKEN_DIM*DATA_WIDTH-1:0]   row_sat
);

  logic signed [2*DATA_WIDTH-1:0] prod   [TOKEN_DIM];
  logic signed [ACC_W-1:0]        sum    [TOKEN_DIM];
  logic signed [ACC_W-1:0]        acc_q  [TOKEN_DIM];
  logic signed [ACC_W-1:0]        acc_d  [TOKEN_DIM];

  // Products, running sums and the rounded row; the row includes the current
  // term so the last column of a row can be written on the same edge it arrives.
  always_comb begin
    row_sat = '0;
    for (int j = 0; j < TOKEN_DIM; j++) begin
      prod[j] = (2 * DATA_WIDTH)'(s_val) *
                (2 * DATA_WIDTH)'($signed(v_row[j*DATA_WIDTH +: DATA_WIDTH]));
      sum[j]  = acc_q[j] + ACC_W'(prod[j]);
      row_sat[j*DATA_WIDTH +: DATA_WIDTH] = round_sat(sum[j]);
    end
  end

  // Next accumulator value: clear has priority over accumulate.
  always_comb begin
    for (int j = 0; j < TOKEN_DIM; j++) begin
      acc_d[j] = acc_q[j];
      if (clr) begin
        acc_d[j] = '0;
      end else if (en) begin
        acc_d[j] = sum[j];
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < TOKEN_DIM; j++) begin
        acc_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < TOKEN_DIM; j++) begin
        acc_q[j] <= acc_d[j];
      end
    end
  end

endmodule

// File: rtl/attn_weighted_sum.sv
// Computes O = S*V, one S column per cycle across TOKEN_DIM MACs, with captured inputs.
// Latency: out_valid rises TOKEN_NUM*TOKEN_NUM edges after the accepting edge.
// Backpressure: O_out/out_valid held in DONE until out_ready; in_ready only in IDLE.
module attn_weighted_sum
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int TOKEN_DIM  = TOK_DIM,
  parameter int TOKEN_NUM  = TOK_NUM,
  parameter int FRAC_BITS  = FRAC_W
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0]   S_in,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]   V_in,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]   O_out
);

  localparam int S_BITS   = DATA_WIDTH * TOKEN_NUM * TOKEN_NUM;
  localparam int V_BITS   = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;
  localparam int ROW_BITS = DATA_WIDTH * TOKEN_DIM;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          i_q, i_d;
  logic [IDX_W-1:0]          k_q, k_d;
  logic [S_BITS-1:0]         s_q, s_d;
  logic [V_BITS-1:0]         v_q, v_d;
  logic [V_BITS-1:0]         o_q, o_d;

  logic                      mac_clr;
  logic                      mac_en;
  logic signed [DATA_WIDTH-1:0] s_val;
  logic [ROW_BITS-1:0]       v_row;
  logic [ROW_BITS-1:0]       mac_row;
  logic                      k_last;
  logic                      i_last;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign O_out     = o_q;

  assign k_last = (k_q == IDX_W'(TOKEN_NUM - 1));
  assign i_last = (i_q == IDX_W'(TOKEN_NUM - 1));

  // Operand selection: S[i][k] and row k of V from the captured copies.
  always_comb begin
    s_val = $signed(s_q[(int'(i_q) * TOKEN_NUM + int'(k_q)) * DATA_WIDTH +: DATA_WIDTH]);
    v_row = v_q[int'(k_q) * ROW_BITS +: ROW_BITS];
  end

  weighted_row_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .TOKEN_DIM  (TOKEN_DIM)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .s_val   (s_val),
    .v_row   (v_row),
    .row_sat (mac_row)
  );

  // Control: capture in IDLE, walk (i,k) in CALC writing a row at each k wrap, hold in DONE.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    s_d     = s_q;
    v_d     = v_q;
    o_d     = o_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d     = S_in;
          v_d     = V_in;
          i_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        mac_en = 1'b1;
        if (k_last) begin
          o_d[int'(i_q) * ROW_BITS +: ROW_BITS] = mac_row;
          mac_clr = 1'b1;
          k_d     = '0;
          i_d     = i_q + IDX_W'(1);
          if (i_last) begin
            state_d = ST_DONE;
          end
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, captured operands and the output matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      k_q     <= '0;
      s_q     <= '0;
      v_q     <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      s_q     <= s_d;
      v_q     <= v_d;
      o_q     <= o_d;
    end
  end

endmodule

// File: tb/tb_attn_weighted_sum.sv
// Self-checking bench for attn_weighted_sum against a plain-arithmetic matrix model.
// Latency: checks the accept-to-out_valid edge count on every transaction.
// Backpressure: holds out_ready low for a while and probes in_valid during DONE.
module tb_attn_weighted_sum;

  localparam int DW = 16;
  localparam int TD = 4;
  localparam int TN = 8;
  localparam int SW = DW * TN * TN;
  localparam int OW = DW * TD * TN;
  localparam int LAT = TN * TN;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] S_in;
  logic [OW-1:0] V_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] O_out;

  attn_weighted_sum #(
    .DATA_WIDTH (DW),
    .TOKEN_DIM  (TD),
    .TOKEN_NUM  (TN),
    .FRAC_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S_in      (S_in),
    .V_in      (V_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O_out     (O_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] sm [TN][TN];
  logic signed [DW-1:0] vm [TN][TD];
  logic [OW-1:0] exp_o;
  bit            exp_armed = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [SW-1:0] pack_s();
    logic [SW-1:0] f = '0;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TN; c++)
        f[(r*TN+c)*DW +: DW] = sm[r][c];
    return f;
  endfunction

  function automatic logic [OW-1:0] pack_v();
    logic [OW-1:0] f = '0;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TD; c++)
        f[(r*TD+c)*DW +: DW] = vm[r][c];
    return f;
  endfunction

  // Reference: O[r][j] = clamp(floor((sum_k S[r][k]*V[k][j] + 128) / 256)).
  function automatic logic [OW-1:0] model_o();
    logic [OW-1:0] res = '0;
    longint acc;
    for (int r = 0; r < TN; r++) begin
      for (int j = 0; j < TD; j++) begin
        acc = 0;
        for (int k = 0; k < TN; k++)
          acc += longint'(sm[r][k]) * longint'(vm[k][j]);
        acc = (acc + 128) >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        res[(r*TD+j)*DW +: DW] = acc[DW-1:0];
      end
    end
    return res;
  endfunction

  function automatic longint o_elem(input int r, input int j);
    logic signed [DW-1:0] e;
    e = O_out[(r*TD+j)*DW +: DW];
    return longint'(e);
  endfunction

  task automatic randomize_inputs();
    for (int b = 0; b < SW / 32; b++) S_in[b*32 +: 32] = $urandom();
    for (int b = 0; b < OW / 32; b++) V_in[b*32 +: 32] = $urandom();
  endtask

  // Every cycle with a result presented must match the model's prediction.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_armed) begin
        check_vec("O_out_vs_model", O_out, exp_o);
      end else begin
        check("unexpected_out_valid", 1, 0);
      end
    end
  end

  // Accept one matrix pair, wait for the result, hold it `hold` cycles, then drain.
  task automatic run_one(input int hold);
    int n;
    logic [OW-1:0] snap;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    S_in     = pack_s();
    V_in     = pack_v();
    exp_o    = model_o();
    in_valid = 1'b1;
    @(posedge clk);
    exp_armed = 1'b1;
    #1;
    in_valid = 1'b0;
    randomize_inputs();
    check("in_ready_after_accept", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
      if (n == 10) randomize_inputs();
    end
    check("latency", n, LAT);
    snap = O_out;
    for (int c = 0; c < hold; c++) begin
      in_valid = (c == 2);
      randomize_inputs();
      @(posedge clk); #1;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check_vec("hold_O_stable", O_out, snap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    exp_armed = 1'b0;
    #1;
    out_ready = 1'b0;
    check("drain_out_valid", int'(out_valid), 0);
    check("drain_in_ready", int'(in_ready), 1);
  endtask

  task automatic clear_mats();
    for (int r = 0; r < TN; r++) begin
      for (int c = 0; c < TN; c++) sm[r][c] = '0;
      for (int c = 0; c < TD; c++) vm[r][c] = '0;
    end
  endtask

  task automatic identity_test();
    clear_mats();
    for (int r = 0; r < TN; r++) begin
      sm[r][r] = 16'sd256;
      for (int c = 0; c < TD; c++) vm[r][c] = DW'($urandom());
    end
    run_one(0);
    check_vec("identity_O_eq_V", O_out, pack_v());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    S_in      = '0;
    V_in      = '0;
    #3;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check_vec("reset_O_zero", O_out, '0);
    #19;
    rst_n = 1'b1;
    @(posedge clk); #1;

    identity_test();

    // Uniform average: every output is 3.5.
    clear_mats();
    for (int r = 0; r < TN; r++) begin
      for (int c = 0; c < TN; c++) sm[r][c] = 16'sd32;
      for (int c = 0; c < TD; c++) vm[r][c] = DW'(256 * r);
    end
    run_one(1);
    for (int r = 0; r < TN; r++)
      for (int j = 0; j < TD; j++)
        check("uniform_elem", o_elem(r, j), 896);

    // Rounding: 0.5 * v rounds half up.
    clear_mats();
    sm[0][0] = 16'sd128;
    vm[0][0] = 16'sd1;
    exp_o = model_o();
    check("model_round_pos", longint'($signed(exp_o[DW-1:0])), 1);
    run_one(0);
    check("round_half_pos", o_elem(0, 0), 1);
    vm[0][0] = -16'sd1;
    run_one(0);
    check("round_half_neg", o_elem(0, 0), 0);
    vm[0][0] = 16'sd3;
    run_one(0);
    check("round_three", o_elem(0, 0), 2);
    check("round_other_zero", o_elem(3, 2), 0);

    // Saturation in both directions.
    for (int r = 0; r < TN; r++) begin
      for (int c = 0; c < TN; c++) sm[r][c] = 16'sd256;
      for (int c = 0; c < TD; c++) vm[r][c] = 16'sh7000;
    end
    run_one(0);
    check("sat_pos_00", o_elem(0, 0), 32767);
    check("sat_pos_73", o_elem(7, 3), 32767);
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TD; c++) vm[r][c] = 16'sh9000;
    exp_o = model_o();
    check("model_sat_neg", longint'($signed(exp_o[DW-1:0])), -32768);
    run_one(0);
    check("sat_neg_00", o_elem(0, 0), -32768);
    check("sat_neg_52", o_elem(5, 2), -32768);

    // Randomized transactions, including one with a long backpressure hold.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < TN; r++) begin
        for (int c = 0; c < TN; c++)
          sm[r][c] = (t < 4) ? DW'(int'($urandom_range(0, 512)) - 256) : DW'($urandom());
        for (int c = 0; c < TD; c++) vm[r][c] = DW'($urandom());
      end
      run_one((t == 0) ? 10 : int'($urandom_range(0, 3)));
    end

    // Reset in the middle of CALC.
    identity_test();
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TN; c++) sm[r][c] = DW'(int'($urandom_range(0, 512)) - 256);
    S_in     = pack_s();
    V_in     = pack_v();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midcalc_out_valid", int'(out_valid), 0);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check_vec("rst_O_zero", O_out, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_in_ready", int'(in_ready), 1);
    check_vec("rst_held_O_zero", O_out, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    identity_test();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
